// File: rtl/rv32m_pkg.sv
// Shared RV32IM decode constants: opcodes, funct fields and the ALU op-enable
// index used to build the one-hot enable vector.
package rv32m_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    typedef enum logic [4:0] {
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU,
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_SLT,
        OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_SLTIU,
        OP_SLLI, OP_SRLI, OP_SRAI,
        OP_SW, OP_SH, OP_SB, OP_LUI, OP_AUIPC
    } op_e;

    localparam int unsigned NUM_OPS = 31;
    typedef logic [NUM_OPS-1:0] op_vec_t;

    // An all-zero result means the encoding has no ALU operation (illegal here).
    function automatic op_vec_t decode_ops(input logic [31:0] instr);
        op_vec_t ops;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        ops = '0;
        opc = instr[6:0];
        f3  = instr[14:12];
        f7  = instr[31:25];
        case (opc)
            OPC_OP: begin
                case (f7)
                    F7_BASE: begin
                        case (f3)
                            F3_ADD_SUB: ops[OP_ADD] = 1'b1;
                            F3_SLL:     ops[OP_SLL] = 1'b1;
                            F3_SLT:     ops[OP_SLT] = 1'b1;
                            F3_XOR:     ops[OP_XOR] = 1'b1;
                            F3_SRL_SRA: ops[OP_SRL] = 1'b1;
                            F3_OR:      ops[OP_OR]  = 1'b1;
                            F3_AND:     ops[OP_AND] = 1'b1;
                            default:    ops = '0;
                        endcase
                    end
                    F7_ALT: begin
                        case (f3)
                            F3_ADD_SUB: ops[OP_SUB] = 1'b1;
                            F3_SRL_SRA: ops[OP_SRA] = 1'b1;
                            default:    ops = '0;
                        endcase
                    end
                    F7_MULDIV: begin
                        case (f3)
                            F3_MUL:    ops[OP_MUL]    = 1'b1;
                            F3_MULH:   ops[OP_MULH]   = 1'b1;
                            F3_MULHSU: ops[OP_MULHSU] = 1'b1;
                            F3_MULHU:  ops[OP_MULHU]  = 1'b1;
                            F3_DIV:    ops[OP_DIV]    = 1'b1;
                            F3_DIVU:   ops[OP_DIVU]   = 1'b1;
                            F3_REM:    ops[OP_REM]    = 1'b1;
                            default:   ops[OP_REMU]   = 1'b1;
                        endcase
                    end
                    default: ops = '0;
                endcase
            end
            OPC_OP_IMM: begin
                case (f3)
                    F3_ADD_SUB: ops[OP_ADDI]  = 1'b1;
                    F3_SLL:     ops[OP_SLLI]  = 1'b1;
                    F3_SLT:     ops[OP_SLTI]  = 1'b1;
                    F3_SLTU:    ops[OP_SLTIU] = 1'b1;
                    F3_XOR:     ops[OP_XORI]  = 1'b1;
                    F3_SRL_SRA: begin
                        if (instr[30]) ops[OP_SRAI] = 1'b1;
                        else           ops[OP_SRLI] = 1'b1;
                    end
                    F3_OR:      ops[OP_ORI]   = 1'b1;
                    default:    ops[OP_ANDI]  = 1'b1;
                endcase
            end
            OPC_STORE: begin
                case (f3)
                    F3_SB:   ops[OP_SB] = 1'b1;
                    F3_SH:   ops[OP_SH] = 1'b1;
                    F3_SW:   ops[OP_SW] = 1'b1;
                    default: ops = '0;
                endcase
            end
            OPC_LUI:   ops[OP_LUI]   = 1'b1;
            OPC_AUIPC: ops[OP_AUIPC] = 1'b1;
            default:   ops = '0;
        endcase
        return ops;
    endfunction

endpackage

// File: rtl/rv32_regfile.sv
// 32x32 integer register file: two asynchronous reads, one synchronous write,
// x0 hardwired to zero.
module rv32_regfile
    import rv32m_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            we,
    input  logic [4:0]      wr_addr,
    input  logic [XLEN-1:0] wr_data
);

    logic [XLEN-1:0] regs [32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
        end else if (we && (wr_addr != 5'd0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rs1_data = (rs1_addr == 5'd0) ? '0 : regs[rs1_addr];
    assign rs2_data = (rs2_addr == 5'd0) ? '0 : regs[rs2_addr];

endmodule

// File: rtl/rv32m_decode_stage.sv
// Decode/operand-fetch stage feeding the RV32IM ALU through one registered
// slot with valid/ready handshaking; owns the register-file writeback port.
module rv32m_decode_stage
    import rv32m_pkg::*;
#(
    parameter logic [31:0] RESET_PC_VAL = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_valid,
    output logic        if_ready,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    input  logic        flush,
    input  logic        wb_en,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        ex_ready,
    output logic        ex_valid,
    output logic [31:0] RS1,
    output logic [31:0] RS2,
    output logic [31:0] IM_32_I,
    output logic [31:0] IM_32_S,
    output logic [31:0] IM_32_U,
    output logic [31:0] PC,
    output logic [4:0]  shift_amount,
    output logic        mul_en, mulh_en, mulhsu_en, mulhu_en,
    output logic        div_en, divu_en, rem_en, remu_en,
    output logic        add_en, sub_en, and_en, or_en, xor_en,
    output logic        sll_en, srl_en, sra_en, slt_en,
    output logic        addi_en, andi_en, ori_en, xori_en, slti_en, sltiu_en,
    output logic        slli_en, srli_en, srai_en,
    output logic        sw_en, sh_en, sb_en, lui_en, auipc_en,
    output logic [4:0]  rd,
    output logic        rd_we,
    output logic        illegal
);

    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [31:0] rf_rs1, rf_rs2, rs1_val, rs2_val;
    logic [4:0]  shamt_d;
    logic        capture, illegal_d, rd_we_d, is_store;
    op_vec_t     ops_d, en_q;

    assign rs1_addr = if_instr[19:15];
    assign rs2_addr = if_instr[24:20];
    assign rd_addr  = if_instr[11:7];

    rv32_regfile u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_data (rf_rs1),
        .rs2_data (rf_rs2),
        .we       (wb_en),
        .wr_addr  (wb_rd),
        .wr_data  (wb_data)
    );

    // Same-cycle writeback forwards into the captured operands.
    assign rs1_val = (wb_en && wb_rd != 5'd0 && wb_rd == rs1_addr) ? wb_data : rf_rs1;
    assign rs2_val = (wb_en && wb_rd != 5'd0 && wb_rd == rs2_addr) ? wb_data : rf_rs2;

    assign if_ready = !ex_valid || ex_ready;
    assign capture  = if_valid && if_ready && !flush;

    always_comb begin
        ops_d     = decode_ops(if_instr);
        illegal_d = (ops_d == '0);
        is_store  = ops_d[OP_SW] || ops_d[OP_SH] || ops_d[OP_SB];
        rd_we_d   = !illegal_d && !is_store && (rd_addr != 5'd0);
        shamt_d   = '0;
        if (ops_d[OP_SLLI] || ops_d[OP_SRLI] || ops_d[OP_SRAI])
            shamt_d = if_instr[24:20];
        else if (ops_d[OP_SLL] || ops_d[OP_SRL] || ops_d[OP_SRA])
            shamt_d = rs2_val[4:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid     <= 1'b0;
            en_q         <= '0;
            illegal      <= 1'b0;
            rd_we        <= 1'b0;
            RS1          <= '0;
            RS2          <= '0;
            IM_32_I      <= '0;
            IM_32_S      <= '0;
            IM_32_U      <= '0;
            PC           <= RESET_PC_VAL;
            shift_amount <= '0;
            rd           <= '0;
        end else if (capture) begin
            ex_valid     <= 1'b1;
            en_q         <= ops_d;
            illegal      <= illegal_d;
            rd_we        <= rd_we_d;
            RS1          <= rs1_val;
            RS2          <= rs2_val;
            IM_32_I      <= {{20{if_instr[31]}}, if_instr[31:20]};
            IM_32_S      <= {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
            IM_32_U      <= {12'h000, if_instr[31:12]};
            PC           <= if_pc;
            shift_amount <= shamt_d;
            rd           <= rd_addr;
        end else if (flush || ex_ready) begin
            // Emptying the slot drops the control bits; operand fields are don't-care.
            ex_valid <= 1'b0;
            en_q     <= '0;
            illegal  <= 1'b0;
            rd_we    <= 1'b0;
        end
    end

    assign mul_en    = en_q[OP_MUL];
    assign mulh_en   = en_q[OP_MULH];
    assign mulhsu_en = en_q[OP_MULHSU];
    assign mulhu_en  = en_q[OP_MULHU];
    assign div_en    = en_q[OP_DIV];
    assign divu_en   = en_q[OP_DIVU];
    assign rem_en    = en_q[OP_REM];
    assign remu_en   = en_q[OP_REMU];
    assign add_en    = en_q[OP_ADD];
    assign sub_en    = en_q[OP_SUB];
    assign and_en    = en_q[OP_AND];
    assign or_en     = en_q[OP_OR];
    assign xor_en    = en_q[OP_XOR];
    assign sll_en    = en_q[OP_SLL];
    assign srl_en    = en_q[OP_SRL];
    assign sra_en    = en_q[OP_SRA];
    assign slt_en    = en_q[OP_SLT];
    assign addi_en   = en_q[OP_ADDI];
    assign andi_en   = en_q[OP_ANDI];
    assign ori_en    = en_q[OP_ORI];
    assign xori_en   = en_q[OP_XORI];
    assign slti_en   = en_q[OP_SLTI];
    assign sltiu_en  = en_q[OP_SLTIU];
    assign slli_en   = en_q[OP_SLLI];
    assign srli_en   = en_q[OP_SRLI];
    assign srai_en   = en_q[OP_SRAI];
    assign sw_en     = en_q[OP_SW];
    assign sh_en     = en_q[OP_SH];
    assign sb_en     = en_q[OP_SB];
    assign lui_en    = en_q[OP_LUI];
    assign auipc_en  = en_q[OP_AUIPC];

endmodule

// File: tb/tb_rv32m_decode_stage.sv
// Table-driven bench for rv32m_decode_stage with a scoreboard queue, plus
// hand-written stall, bypass, flush and mid-run reset sequences.
module tb_rv32m_decode_stage;

    localparam logic [31:0] RST_PC = 32'h0000_1000;

    // Bit positions in en_vec below (mul at MSB, auipc at LSB).
    localparam int B_AUIPC = 0,  B_LUI = 1,   B_SB = 2,    B_SW = 4,    B_SRAI = 5;
    localparam int B_SRLI = 6,   B_ADDI = 13, B_SLL = 17,  B_SUB = 21,  B_ADD = 22;
    localparam int B_DIVU = 25,  B_MULHSU = 28, B_MUL = 30;

    logic        clk = 1'b0;
    logic        rst_n, if_valid, if_ready, flush, wb_en, ex_ready, ex_valid;
    logic [31:0] if_instr, if_pc, wb_data;
    logic [4:0]  wb_rd, shift_amount, rd;
    logic [31:0] RS1, RS2, IM_32_I, IM_32_S, IM_32_U, PC;
    logic        mul_en, mulh_en, mulhsu_en, mulhu_en, div_en, divu_en, rem_en, remu_en;
    logic        add_en, sub_en, and_en, or_en, xor_en, sll_en, srl_en, sra_en, slt_en;
    logic        addi_en, andi_en, ori_en, xori_en, slti_en, sltiu_en;
    logic        slli_en, srli_en, srai_en, sw_en, sh_en, sb_en, lui_en, auipc_en;
    logic        rd_we, illegal;
    logic [30:0] en_vec;

    always #5 clk = ~clk;

    rv32m_decode_stage #(.RESET_PC_VAL(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(if_ready),
        .if_instr(if_instr), .if_pc(if_pc), .flush(flush),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_ready(ex_ready), .ex_valid(ex_valid),
        .RS1(RS1), .RS2(RS2), .IM_32_I(IM_32_I), .IM_32_S(IM_32_S), .IM_32_U(IM_32_U),
        .PC(PC), .shift_amount(shift_amount),
        .mul_en(mul_en), .mulh_en(mulh_en), .mulhsu_en(mulhsu_en), .mulhu_en(mulhu_en),
        .div_en(div_en), .divu_en(divu_en), .rem_en(rem_en), .remu_en(remu_en),
        .add_en(add_en), .sub_en(sub_en), .and_en(and_en), .or_en(or_en), .xor_en(xor_en),
        .sll_en(sll_en), .srl_en(srl_en), .sra_en(sra_en), .slt_en(slt_en),
        .addi_en(addi_en), .andi_en(andi_en), .ori_en(ori_en), .xori_en(xori_en),
        .slti_en(slti_en), .sltiu_en(sltiu_en),
        .slli_en(slli_en), .srli_en(srli_en), .srai_en(srai_en),
        .sw_en(sw_en), .sh_en(sh_en), .sb_en(sb_en), .lui_en(lui_en), .auipc_en(auipc_en),
        .rd(rd), .rd_we(rd_we), .illegal(illegal)
    );

    assign en_vec = {mul_en, mulh_en, mulhsu_en, mulhu_en, div_en, divu_en, rem_en, remu_en,
                     add_en, sub_en, and_en, or_en, xor_en, sll_en, srl_en, sra_en, slt_en,
                     addi_en, andi_en, ori_en, xori_en, slti_en, sltiu_en,
                     slli_en, srli_en, srai_en, sw_en, sh_en, sb_en, lui_en, auipc_en};

    // imm_sel: 0 none, 1 IM_32_I, 2 IM_32_S, 3 IM_32_U
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [30:0] en;
        logic        ill;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  sh;
        int          imm_sel;
        logic [31:0] imm;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    vec_t e;
    int   checks = 0, failures = 0, cyc = 0;
    logic mon_en = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [30:0] onehot(input int b);
        logic [30:0] v;
        v = '0;
        v[b] = 1'b1;
        return v;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (ex_valid && ex_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected actual=ex_valid required=empty_slot");
                end else begin
                    e = sb.pop_front();
                    chk("sb_en",      {1'b0, en_vec}, {1'b0, e.en});
                    chk("sb_illegal", {31'd0, illegal}, {31'd0, e.ill});
                    chk("sb_rd_we",   {31'd0, rd_we}, {31'd0, e.we});
                    chk("sb_rd",      {27'd0, rd}, {27'd0, e.rd});
                    chk("sb_rs1",     RS1, e.rs1);
                    chk("sb_rs2",     RS2, e.rs2);
                    chk("sb_shamt",   {27'd0, shift_amount}, {27'd0, e.sh});
                    chk("sb_pc",      PC, e.pc);
                    case (e.imm_sel)
                        1: chk("sb_imm_i", IM_32_I, e.imm);
                        2: chk("sb_imm_s", IM_32_S, e.imm);
                        3: chk("sb_imm_u", IM_32_U, e.imm);
                        default: ;
                    endcase
                end
            end else if (!ex_valid) begin
                chk("idle_en_zero", {1'b0, en_vec}, 32'd0);
            end
        end
    end

    task automatic send(input vec_t v);
        int n;
        n = 0;
        if_valid = 1'b1;
        if_instr = v.instr;
        if_pc    = v.pc;
        @(negedge clk);
        while (!if_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=if_ready_low required=if_ready_high");
        end
        sb.push_back(v);
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        wb_en = 1'b1; wb_rd = a; wb_data = d;
        @(posedge clk);
        #1;
        wb_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        // instr, pc, en, ill, we, rd, rs1, rs2, sh, imm_sel, imm   (x1=0x10, x2=0x4)
        tbl.push_back('{32'h002081B3, 32'h100, onehot(B_ADD),    1'b0, 1'b1, 5'd3,  32'h10, 32'h4,  5'd0, 0, 32'h0});
        tbl.push_back('{32'hFF008293, 32'h104, onehot(B_ADDI),   1'b0, 1'b1, 5'd5,  32'h10, 32'h0,  5'd0, 1, 32'hFFFFFFF0});
        tbl.push_back('{32'h4020D313, 32'h108, onehot(B_SRAI),   1'b0, 1'b1, 5'd6,  32'h10, 32'h4,  5'd2, 0, 32'h0});
        tbl.push_back('{32'h000123B7, 32'h10C, onehot(B_LUI),    1'b0, 1'b1, 5'd7,  32'h4,  32'h0,  5'd0, 3, 32'h00000012});
        tbl.push_back('{32'h0020A423, 32'h110, onehot(B_SW),     1'b0, 1'b0, 5'd8,  32'h10, 32'h4,  5'd0, 2, 32'h00000008});
        tbl.push_back('{32'h0020B1B3, 32'h114, 31'd0,            1'b1, 1'b0, 5'd3,  32'h10, 32'h4,  5'd0, 0, 32'h0});
        tbl.push_back('{32'h00209433, 32'h118, onehot(B_SLL),    1'b0, 1'b1, 5'd8,  32'h10, 32'h4,  5'd4, 0, 32'h0});
        tbl.push_back('{32'h402084B3, 32'h11C, onehot(B_SUB),    1'b0, 1'b1, 5'd9,  32'h10, 32'h4,  5'd0, 0, 32'h0});
        tbl.push_back('{32'h0220D533, 32'h120, onehot(B_DIVU),   1'b0, 1'b1, 5'd10, 32'h10, 32'h4,  5'd0, 0, 32'h0});
        tbl.push_back('{32'h00208033, 32'h124, onehot(B_ADD),    1'b0, 1'b0, 5'd0,  32'h10, 32'h4,  5'd0, 0, 32'h0});
        tbl.push_back('{32'h000000EF, 32'h128, 31'd0,            1'b1, 1'b0, 5'd1,  32'h0,  32'h0,  5'd0, 0, 32'h0});
        tbl.push_back('{32'h00115593, 32'h12C, onehot(B_SRLI),   1'b0, 1'b1, 5'd11, 32'h4,  32'h10, 5'd1, 0, 32'h0});
        tbl.push_back('{32'hFE110FA3, 32'h130, onehot(B_SB),     1'b0, 1'b0, 5'd31, 32'h4,  32'h10, 5'd0, 2, 32'hFFFFFFFF});
        tbl.push_back('{32'hFFFFF617, 32'h134, onehot(B_AUIPC),  1'b0, 1'b1, 5'd12, 32'h0,  32'h0,  5'd0, 3, 32'h000FFFFF});
        tbl.push_back('{32'h0220A6B3, 32'h138, onehot(B_MULHSU), 1'b0, 1'b1, 5'd13, 32'h10, 32'h4,  5'd0, 0, 32'h0});
        tbl.push_back('{32'h40209733, 32'h13C, 31'd0,            1'b1, 1'b0, 5'd14, 32'h10, 32'h4,  5'd0, 0, 32'h0});

        rst_n = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0; flush = 1'b0;
        wb_en = 1'b0; wb_rd = '0; wb_data = '0; ex_ready = 1'b1;

        #12;
        chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_en",       {1'b0, en_vec}, 32'd0);
        chk("rst_illegal",  {31'd0, illegal}, 32'd0);
        chk("rst_rd_we",    {31'd0, rd_we}, 32'd0);
        chk("rst_rs1",      RS1, 32'd0);
        chk("rst_rs2",      RS2, 32'd0);
        chk("rst_imm_i",    IM_32_I, 32'd0);
        chk("rst_imm_s",    IM_32_S, 32'd0);
        chk("rst_imm_u",    IM_32_U, 32'd0);
        chk("rst_shamt",    {27'd0, shift_amount}, 32'd0);
        chk("rst_rd",       {27'd0, rd}, 32'd0);
        chk("rst_pc",       PC, RST_PC);
        chk("rst_if_ready", {31'd0, if_ready}, 32'd1);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        wb_write(5'd1, 32'h10);
        wb_write(5'd2, 32'h4);
        wb_write(5'd0, 32'hDEAD);
        @(negedge clk);
        chk("idle_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("idle_pc", PC, RST_PC);
        @(posedge clk);
        #1;

        mon_en = 1'b1;
        t0 = cyc;
        foreach (tbl[i]) send(tbl[i]);
        chk("throughput_cycles", cyc - t0, tbl.size());
        if_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 32'd0);
        mon_en = 1'b0;

        // Stall: slot held for three cycles while fetch keeps offering.
        ex_ready = 1'b0; if_valid = 1'b1; if_instr = 32'h002081B3; if_pc = 32'h200;
        @(posedge clk);
        #1;
        if_instr = 32'h402084B3; if_pc = 32'h204;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_if_ready", {31'd0, if_ready}, 32'd0);
            chk("stall_ex_valid", {31'd0, ex_valid}, 32'd1);
            chk("stall_en",       {1'b0, en_vec}, {1'b0, onehot(B_ADD)});
            chk("stall_rs1",      RS1, 32'h10);
            chk("stall_pc",       PC, 32'h200);
            @(posedge clk);
            #1;
        end
        ex_ready = 1'b1;
        @(negedge clk);
        chk("release_if_ready", {31'd0, if_ready}, 32'd1);
        @(posedge clk);
        #1;
        if_valid = 1'b0;
        @(negedge clk);
        chk("b2b_ex_valid", {31'd0, ex_valid}, 32'd1);
        chk("b2b_en",       {1'b0, en_vec}, {1'b0, onehot(B_SUB)});
        chk("b2b_pc",       PC, 32'h204);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("drain_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("drain_en",       {1'b0, en_vec}, 32'd0);

        // Bypass: writeback to x1 in the capture cycle of mul x4,x1,x2.
        @(posedge clk);
        #1;
        if_valid = 1'b1; if_instr = 32'h02208233; if_pc = 32'h300;
        wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'hABCD;
        @(posedge clk);
        #1;
        if_valid = 1'b0; wb_en = 1'b0; ex_ready = 1'b0;
        @(negedge clk);
        chk("byp_rs1",   RS1, 32'hABCD);
        chk("byp_rs2",   RS2, 32'h4);
        chk("byp_en",    {1'b0, en_vec}, {1'b0, onehot(B_MUL)});
        chk("byp_rd",    {27'd0, rd}, 32'd4);
        chk("byp_rd_we", {31'd0, rd_we}, 32'd1);

        // Flush with held slot and an incoming instruction; writeback still lands.
        @(posedge clk);
        #1;
        flush = 1'b1; if_valid = 1'b1; if_instr = 32'h002081B3; if_pc = 32'h304;
        wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'h77;
        @(posedge clk);
        #1;
        flush = 1'b0; if_valid = 1'b0; wb_en = 1'b0;
        @(negedge clk);
        chk("flush_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("flush_en",       {1'b0, en_vec}, 32'd0);
        chk("flush_if_ready", {31'd0, if_ready}, 32'd1);
        @(posedge clk);
        #1;
        if_valid = 1'b1; if_instr = 32'h000281B3; if_pc = 32'h308;
        @(posedge clk);
        #1;
        if_valid = 1'b0;
        @(negedge clk);
        chk("postflush_ex_valid", {31'd0, ex_valid}, 32'd1);
        chk("postflush_rs1_x5",   RS1, 32'h77);
        chk("postflush_rs2_x0",   RS2, 32'h0);
        chk("postflush_pc",       PC, 32'h308);

        // Asynchronous reset while a slot is held.
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("midrst_en",       {1'b0, en_vec}, 32'd0);
        chk("midrst_pc",       PC, RST_PC);
        chk("midrst_rs1",      RS1, 32'd0);
        chk("midrst_rd",       {27'd0, rd}, 32'd0);
        chk("midrst_rd_we",    {31'd0, rd_we}, 32'd0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        ex_ready = 1'b1; if_valid = 1'b1; if_instr = 32'h002081B3; if_pc = 32'h400;
        @(posedge clk);
        #1;
        if_valid = 1'b0;
        @(negedge clk);
        chk("rfclr_ex_valid", {31'd0, ex_valid}, 32'd1);
        chk("rfclr_rs1",      RS1, 32'd0);
        chk("rfclr_rs2",      RS2, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rv32m_decode_stage.md
# rv32m_decode_stage

Decode/operand-fetch stage directly upstream of the RV32IM ALU. Accepts a fetched instruction and PC, decodes it into the ALU's one-hot operation enables, reads a 32x32 register file, builds the I/S/U immediates and shift amount, and presents everything to the ALU from a single registered pipeline slot with valid/ready handshaking. The writeback port into the register file is also owned here.

## Interface
Parameters:
- RESET_PC_VAL, 32'h0000_0000: reset value of the registered PC output.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous, active-low.
- if_valid  in  1  fetch offers an instruction.
- if_ready  out  1  stage accepts this cycle.
- if_instr  in  32  instruction word.
- if_pc  in  32  its PC.
- flush  in  1  squash the held and incoming instruction.
- wb_en  in  1  register-file write strobe.
- wb_rd  in  5  write address.
- wb_data  in  32  write data.
- ex_ready  in  1  ALU/EX consumes the slot this cycle.
- ex_valid  out  1  slot holds a decoded instruction.
- RS1, RS2  out  32 each  register operands.
- IM_32_I, IM_32_S, IM_32_U  out  32 each  immediates.
- PC  out  32  instruction PC.
- shift_amount  out  5  shift distance.
- 31 op enables  out  1 each: mul_en mulh_en mulhsu_en mulhu_en div_en divu_en rem_en remu_en add_en sub_en and_en or_en xor_en sll_en srl_en sra_en slt_en addi_en andi_en ori_en xori_en slti_en sltiu_en slli_en srli_en srai_en sw_en sh_en sb_en lui_en auipc_en.
- rd  out  5  destination register.
- rd_we  out  1  instruction writes rd.
- illegal  out  1  instruction not decodable to an ALU enable.

## Operation
- Decode: OP (0110011) funct7 0000000/0100000/0000001 -> R/M enables; OP-IMM (0010011) -> I enables, srai when instr[30]=1; STORE (0100011) funct3 000/001/010 -> sb/sh/sw; LUI (0110111); AUIPC (0010111).
- SLTU, loads, branches, JAL/JALR, SYSTEM, FENCE, any other encoding: all enables 0, illegal=1, rd_we=0.
- Exactly one enable high when ex_valid=1 and illegal=0; all enables 0 whenever ex_valid=0.
- IM_32_I = sign-extended instr[31:20]; IM_32_S = sign-extended {instr[31:25],instr[11:7]}; IM_32_U = zero-extended instr[31:12] (unshifted; ALU applies <<12).
- shift_amount = instr[24:20] for slli/srli/srai; RS2[4:0] for sll/srl/sra; 0 otherwise.
- rd = instr[11:7]; rd_we = 1 for all legal non-store ops and rd != 0.
- Register file: x0 reads 0, writes to x0 ignored; write when wb_en=1 at posedge.
- Bypass: if wb_en=1 and wb_rd == rs1/rs2 (nonzero) in the capture cycle, RS1/RS2 capture wb_data.
- RAW hazards against the instruction in EX are resolved by the pipeline controller via ex_ready; not detected here.

## Timing
- Reset: ex_valid=0, all enables 0, illegal=0, rd_we=0, RS1/RS2/immediates/shift_amount/rd=0, PC=RESET_PC_VAL, all registers x1..x31=0.
- if_ready = !ex_valid || ex_ready (combinational, no flush dependency).
- Capture when if_valid && if_ready && !flush; outputs valid the next cycle (latency 1).
- ex_valid falls next cycle when ex_ready=1 and no capture; holds with all outputs stable while ex_ready=0.
- flush=1: ex_valid=0 next cycle, incoming instruction dropped, regfile write still performed.
- Simultaneous consume and capture: slot replaced, ex_valid stays 1 (full throughput).
- Reset asserted mid-operation: immediate return to reset values, pending slot lost.

## Structure
- Package rv32m_pkg: opcode, funct3, funct7 constants; op-enable index enum; XLEN=32.
- Sub-module rv32_regfile (2 async read, 1 sync write, async reset, x0 hardwired); decode and pipeline register stay in this module.

## Test plan
- Reset release, idle: all outputs at reset values, if_ready=1, ex_valid=0.
- wb x1=0x10, x2=0x4; send add x3,x1,x2 (0x002081B3) -> next cycle ex_valid=1, add_en=1, RS1=0x10, RS2=0x4, rd=3, rd_we=1.
- addi x5,x1,-16 (0xFF008293) -> addi_en=1, IM_32_I=0xFFFFFFF0; srai x6,x1,2 (0x4020D313) -> srai_en=1, shift_amount=2.
- lui x7,0x12 (0x000123B7) -> lui_en=1, IM_32_U=0x00000012; sw x2,8(x1) (0x0020A423) -> sw_en=1, IM_32_S=0x8, rd_we=0; sltu (0x0020B1B3) -> illegal=1, no enables.
- ex_ready=0 for 3 cycles with if_valid=1 -> if_ready=0, outputs stable; then ex_ready=1 -> back-to-back acceptance, one instr/cycle.
- Bypass: wb_en=1, wb_rd=1, wb_data=0xABCD in capture cycle of mul x4,x1,x2 -> RS1=0xABCD, mul_en=1; flush with held slot -> ex_valid=0 next cycle.
